// File: rtl/barrel_shifter_arbiter_if.sv
// Bundle of request, result and status signals between the two ALU-side
// requesters, the result consumer and barrel_shifter_arbiter.
//   req0_*/req1_* : operand/amount valid-ready channels, one per requester
//   res_*         : rotated result with owning requester ID, valid-ready
//   busy          : arbiter is not idle
// slave  : the arbiter side (requests in, results out)
// master : the requester/consumer side
interface barrel_shifter_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req0_amt,
        input  req1_valid, req1_data, req1_amt,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_data, res_id, busy
    );

    modport master (
        output req0_valid, req0_data, req0_amt,
        output req1_valid, req1_data, req1_amt,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/barrel_shifter_arbiter.sv
// Round-robin sharing of one rotate-right barrel shifter between two
// requesters. One request is latched in IDLE, rotated in SHIFT, and the
// registered result plus requester ID is offered in DONE until taken.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/result/status bundle (slave side)
module barrel_shifter_arbiter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    barrel_shifter_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;
    logic             prio_q, prio_d;

    logic             grant0, grant1;
    logic             ready0, ready1;
    logic [WIDTH-1:0] rot;

    // A lone valid requester always wins; prio only breaks ties.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | ~prio_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | prio_q);
        ready0 = (state_q == IDLE) & grant0;
        ready1 = (state_q == IDLE) & grant1;
    end

    // Bit i takes op[(i+amt) mod WIDTH]; the AMT_W-bit index wraps naturally.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rot[i] = op_q[AMT_W'(i) + amt_q];
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        amt_d       = amt_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        prio_d      = prio_q;
        case (state_q)
            IDLE: begin
                if (ready0) begin
                    op_d    = bus.req0_data;
                    amt_d   = bus.req0_amt;
                    id_d    = 1'b0;
                    state_d = SHIFT;
                end else if (ready1) begin
                    op_d    = bus.req1_data;
                    amt_d   = bus.req1_amt;
                    id_d    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_data_d  = rot;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    prio_d      = ~id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            amt_q       <= '0;
            id_q        <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            amt_q       <= amt_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            prio_q      <= prio_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/barrel_shifter_arbiter.md
Name: barrel_shifter_arbiter

Overview:
Shares one 8-bit rotate-right barrel shifter between two requesters using a round-robin policy. Each requester sends operand and amount over a valid/ready handshake. The block latches one request, computes the rotation, and returns the registered result and requester ID over a valid/ready result handshake. It sits between the ALU-side requesters and the shifter datapath, and contains its own rotate logic.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of two.
AMT_W, 3, shift-amount width; equals log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_data  input  WIDTH  requester 0 operand
req0_amt  input  AMT_W  requester 0 rotate-right amount
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_data  input  WIDTH  requester 1 operand
req1_amt  input  AMT_W  requester 1 rotate-right amount
res_valid  output  1  result available
res_ready  input  1  consumer takes the result
res_data  output  WIDTH  rotated operand
res_id  output  1  requester that owns res_data
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - state=IDLE, res_valid=0, res_data=0, res_id=0, prio=0 (requester 0 favoured).
  - Internal operand/amount/id registers are cleared.
  - An op in flight is discarded and no result is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - grant = the valid requester if only one is valid. If both are valid, grant = prio.
  - reqN_ready = (state==IDLE) & granted(N), combinational. At most one ready is high per cycle. Ready stays 0 in SHIFT and DONE.
  - On a handshake: latch data, amt and id, then go to SHIFT.
  - If no requester is valid, stay in IDLE.
- SHIFT:
  - res_data <= rotate_right(op, amt), where bit i of the result = op[(i+amt) mod WIDTH]. amt=0 passes the operand through.
  - res_id <= id, res_valid <= 1, go to DONE.
- DONE:
  - Hold res_valid, res_data and res_id stable until res_ready=1.
  - On the handshake: res_valid <= 0, prio <= ~id (the other requester is favoured next), go to IDLE.
  - res_data keeps its last value after res_valid drops.
- Latency and throughput:
  - Accept at edge N gives res_valid=1 after edge N+1.
  - If res_ready is held high, res_valid is high for exactly one cycle.
  - Minimum spacing between accepts is 3 cycles.
- Requester inputs are don't-care except in IDLE. A requester may drop valid before it is granted; no op is recorded for it.
- prio changes only on a result handshake. A lone requester is always served, whatever prio is.
- res_ready asserted while res_valid=0 has no effect.

Test Plan:
1. Reset, then req0 only with data=8'b10101011, amt=3 -> req0_ready pulses 1 cycle; 2 cycles later res_valid=1, res_data=8'b01110101, res_id=0; busy high from the accept until the result handshake.
2. Sweep amt 0..7 on req1 with data=8'b10101011 -> res_data = 10101011, 11010101, 11101010, 01110101, 10111010, 01011101, 10101110, 01010111, all with res_id=1.
3. Both requesters valid continuously (req0 data=8'h01 amt=1, req1 data=8'h80 amt=7) -> grants alternate 0,1,0,1; results are 8'h80 for id 0 and 8'h01 for id 1.
4. Backpressure: res_ready held 0 for 5 cycles after res_valid -> res_valid, res_data and res_id stay stable; req0_ready and req1_ready stay 0; release gives one handshake, then a return to IDLE.
5. Reset mid-op: assert rst_n=0 in SHIFT -> next cycle res_valid=0, busy=0, prio=0; no result appears for the aborted op; the next request is served normally.
6. Lone requester after a grant (req0 served, then only req0 valid again) -> req0 is granted again, even though prio=1.
